// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed NUM_DIGITS hex display driver.
// Each digit is lit for DIV cycles and followed by a one-cycle dark GAP
// that suppresses ghosting. New values are loaded at frame boundaries only,
// so a frame never mixes old and new digits. The display also supports
// leading-zero blanking and per-digit blank masking.
// Optional decimal-point support is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lzb_en,
`ifdef SEG7_SCAN_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    dp,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {SHOW, GAP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, pending_q;
  logic                    pend_q;

  logic                    wrap;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   an_d;
`ifdef SEG7_SCAN_DP_EN
  logic                    dp_d;
`endif

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h18;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      4'hF: decode = 7'h0E;
    endcase
  endfunction

  // Scan state register: SHOW/GAP phase, prescaler and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: DIV cycles of SHOW, then one GAP that advances the index.
  always_comb begin
    // NOTE: hold-current defaults first, so no path leaves a signal
    // unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = SHOW;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      default: state_d = SHOW;
    endcase
  end

  // The GAP of the last digit is the frame boundary.
  assign wrap = (state_q == GAP) && (idx_q == IDX_LAST);

  // Leading-zero blanking: digit i is dark when it and every higher digit are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (shadow_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lzb_en && zero_run;
    end
  end

  assign cur_nib   = shadow_q[4*int'(idx_q) +: 4];
  assign cur_blank = blank_mask[idx_q] | lz_blank[idx_q];

  // Output pattern for the current scan position; GAP and blanked digits stay dark.
  always_comb begin
    seg_d = 7'h7F;
    an_d  = '1;
`ifdef SEG7_SCAN_DP_EN
    dp_d  = 1'b1;
`endif
    if (state_q == SHOW && !cur_blank) begin
      seg_d        = decode(cur_nib);
      an_d[idx_q]  = 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_d         = ~dp_mask[idx_q];
`endif
    end
  end

  // Registered outputs; frame_done marks the cycle after the wrap GAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg        <= 7'h7F;
      an         <= '1;
      frame_done <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp         <= 1'b1;
`endif
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= wrap;
`ifdef SEG7_SCAN_DP_EN
      dp         <= dp_d;
`endif
    end
  end

  // Pending/shadow pair: loads collect in pending and move to shadow only at
  // the frame boundary, so the display never tears mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: shadow and pending are reset, unlike plain data storage,
      // because shadow drives the display directly after reset.
      shadow_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        shadow_q  <= value;
        pending_q <= value;
      end else if (pend_q) begin
        shadow_q  <= pending_q;
      end
      pend_q <= 1'b0;
    end else if (load) begin
      pending_q <= value;
      pend_q    <= 1'b1;
    end
  end

endmodule
